// File: rtl/multiplier.sv
// multiplier: multi-cycle IEEE-754 single-precision multiplier with serial shift-add significand product
module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] P,
  output logic        done
);
  typedef enum logic [1:0] {LOAD, MUL, NORM, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] a_r, b_r, p_nx;
  logic [47:0] acc, mcand;
  logic [4:0] cnt;
  logic [23:0] sig_b, frac_w;
  logic signed [9:0] exp_s;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  always_comb begin
    state_nx = state;
    case (state)
      LOAD: state_nx = MUL;
      MUL:  state_nx = (cnt == 5'd23) ? NORM : MUL;
      NORM: state_nx = DONE;
      default: state_nx = DONE;
    endcase
  end
  always_comb begin
    sgn    = a_r[31] ^ b_r[31];
    a_zero = a_r[30:23] == 8'd0;
    b_zero = b_r[30:23] == 8'd0;
    a_inf  = a_r[30:23] == 8'hFF && a_r[22:0] == 23'd0;
    b_inf  = b_r[30:23] == 8'hFF && b_r[22:0] == 23'd0;
    a_nan  = a_r[30:23] == 8'hFF && a_r[22:0] != 23'd0;
    b_nan  = b_r[30:23] == 8'hFF && b_r[22:0] != 23'd0;
    sig_b  = b_zero ? 24'd0 : {1'b1, b_r[22:0]};
    exp_s  = $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127
           + $signed({9'd0, acc[47]});
    frac_w = {1'b0, acc[47] ? acc[46:24] : acc[45:23]};
    p_nx   = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? 32'h7FC00000 :
             (a_inf || b_inf)          ? {sgn, 8'hFF, 23'd0} :
             (a_zero || b_zero)        ? {sgn, 31'd0} :
             (exp_s >= 10'sd255)       ? {sgn, 8'hFF, 23'd0} :
             (exp_s <= 10'sd0)         ? {sgn, 31'd0} :
                                         {sgn, exp_s[7:0], frac_w[22:0]};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        a_r   <= A;
        b_r   <= B;
        acc   <= '0;
        cnt   <= '0;
        mcand <= {24'd0, (A[30:23] == 8'd0) ? 24'd0 : {1'b1, A[22:0]}};
      end
      if (state == MUL) begin
        acc   <= acc + (sig_b[cnt] ? mcand : 48'd0);
        mcand <= mcand << 1;
        cnt   <= cnt + 5'd1;
      end
      if (state == NORM) begin
        P    <= p_nx;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: randomized self-checking bench against an arithmetic float-multiply model
module tb_multiplier;
  logic clk = 0, rst = 0;
  logic [31:0] A = 0, B = 0, P;
  logic done;
  int errs = 0, checks = 0;

  multiplier dut (.clk(clk), .rst(rst), .A(A), .B(B), .P(P), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint fa, fb, prod, frac;
    logic [31:0] r;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    prod = (fa + (64'sd1 <<< 23)) * (fb + (64'sd1 <<< 23));
    e = ea + eb - 127;
    if (prod >= (64'sd1 <<< 47)) begin
      e++;
      frac = (prod >>> 24) % (64'sd1 <<< 23);
    end else frac = (prod >>> 23) % (64'sd1 <<< 23);
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    r = {s, 8'(e), 23'(frac)};
    return r;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = 0;
    A = a; B = b;
    @(negedge clk);
    chk("reset_p", P, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    logic [31:0] exp;
    exp = ref_mul(a, b);
    start(a, b);
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (scramble && i >= 2) begin A = $urandom; B = $urandom; end
    end
    chk({tag, "_early_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_early_p"}, P, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk(tag, P, exp);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, P, exp);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) v[22:0] = 23'd0;
    else if (k < 6) v[30:23] = 8'(96 + $urandom_range(0, 63));
    return v;
  endfunction

  initial begin
    run("two_x_three", 32'h40000000, 32'h40400000, 0);
    run("bit47_norm", 32'h3FC00000, 32'h3FC00000, 0);
    run("trunc", 32'h3F800001, 32'h3F800001, 0);
    run("neg", 32'hC0000000, 32'h3F000000, 0);
    run("zero", 32'h00000000, 32'hC0A00000, 0);
    run("inf_zero", 32'h7F800000, 32'h00000000, 0);
    run("overflow", 32'h7F000000, 32'h40000000, 0);
    run("underflow", 32'h00800000, 32'h00800000, 0);
    run("nan", 32'hFFC12345, 32'h3F800000, 0);
    run("neg_inf", 32'hFF800000, 32'h40000000, 0);
    run("scramble", 32'h40400000, 32'h40A00000, 1);
    start(32'h40000000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_p", P, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort_hold_done", {31'd0, done}, 32'd0);
    end
    run("after_abort", 32'h40800000, 32'h40800000, 0);
    for (int i = 0; i < 40; i++) run("random", rnd_op(), rnd_op(), i % 4 == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
